// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types, constants and address checking for the
//            data-memory responder and its word RAM.
// Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    RESP = 3'd2,
    DUMP = 3'd3,
    DONE = 3'd4
  } state_t;

  // A byte address is unusable if it is not word aligned or if any bit above
  // the word-index field is set (the array would otherwise silently alias).
  function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
    logic [31:0] upper;
    upper = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (upper != 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_1rw.sv
`default_nettype none
// ============================================================================
// Module   : ram_1rw
// Purpose  : Single-port synchronous word RAM, read-before-write. Contents
//            are intentionally not reset.
// Revision : 1.0  initial release
// ============================================================================
module ram_1rw
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // One access per cycle: optional write, registered read of the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Slow memory model for the CPU load/store port. One request at a
//            time, WAIT_CYCLES wait states, one-cycle response; on fin_sign
//            the whole array is streamed out for end-of-program checking.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic              fin_sign,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [31:0]       dump_data,
  output logic              dump_done
);

  localparam logic [3:0]        c_wait_load = 4'(WAIT_CYCLES);
  localparam logic              c_zero_wait = (WAIT_CYCLES == 0);
  localparam logic [ADDR_W-1:0] c_last_idx  = '1;

  state_t              r_state;
  logic [3:0]          r_wait_cnt;
  logic                r_write;
  logic                r_err;
  logic [ADDR_W-1:0]   r_idx;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_fin_pend;
  logic [ADDR_W-1:0]   r_dump_cnt;
  logic                r_resp_data;

  logic                w_accept;
  logic                w_req_err;
  logic [ADDR_W-1:0]   w_req_idx;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [WORD_W-1:0]   w_ram_wdata;
  logic [WORD_W-1:0]   w_ram_rdata;

  // fin_sign takes priority over a new request, so ready drops with it to
  // keep the handshake honest.
  assign req_ready = (r_state == IDLE) && !rst && !fin_sign;
  assign w_accept  = req_valid && req_ready;
  assign w_req_err = addr_err(req_addr, ADDR_W);
  assign w_req_idx = req_addr[ADDR_W+1:2];

  // The RAM's registered read data is only meaningful in the cycle after the
  // access; gate it so idle outputs read as zero.
  assign resp_rdata = r_resp_data ? w_ram_rdata : '0;
  assign dump_data  = dump_valid  ? w_ram_rdata : '0;

  // RAM port arbitration: the transaction access happens on the edge that
  // enters RESP; in DUMP the port walks the dump counter.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = r_idx;
    w_ram_wdata = r_wdata;
    case (r_state)
      IDLE: begin
        if (c_zero_wait && w_accept) begin
          w_ram_addr  = w_req_idx;
          w_ram_wdata = req_wdata;
          w_ram_we    = req_write && !w_req_err;
        end
      end
      WAIT: begin
        if (r_wait_cnt == 4'd1) begin
          w_ram_we = r_write && !r_err;
        end
      end
      DUMP: begin
        w_ram_addr = r_dump_cnt;
      end
      default: ;
    endcase
    // A reset landing on the commit edge must abort the store.
    if (rst) begin
      w_ram_we = 1'b0;
    end
  end

  ram_1rw #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

  // Control FSM with request latches, wait counter, dump counter and
  // registered response/dump outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_fin_pend  <= 1'b0;
      r_dump_cnt  <= '0;
      r_resp_data <= 1'b0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      dump_valid  <= 1'b0;
      dump_addr   <= '0;
      dump_done   <= 1'b0;
    end else begin
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      r_resp_data <= 1'b0;
      dump_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (fin_sign) begin
            r_state    <= DUMP;
            r_dump_cnt <= '0;
          end else if (w_accept) begin
            r_write    <= req_write;
            r_err      <= w_req_err;
            r_idx      <= w_req_idx;
            r_wdata    <= req_wdata;
            r_wait_cnt <= c_wait_load;
            if (c_zero_wait) begin
              r_state     <= RESP;
              resp_valid  <= 1'b1;
              resp_err    <= w_req_err;
              r_resp_data <= !req_write && !w_req_err;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (fin_sign) begin
            r_fin_pend <= 1'b1;
          end
          if (r_wait_cnt == 4'd1) begin
            r_state     <= RESP;
            resp_valid  <= 1'b1;
            resp_err    <= r_err;
            r_resp_data <= !r_write && !r_err;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (r_fin_pend || fin_sign) begin
            r_state    <= DUMP;
            r_dump_cnt <= '0;
            r_fin_pend <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        DUMP: begin
          // Output index trails the RAM address by the one-cycle read latency.
          dump_valid <= 1'b1;
          dump_addr  <= r_dump_cnt;
          r_dump_cnt <= r_dump_cnt + 1'b1;
          if (r_dump_cnt == c_last_idx) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          dump_done <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed self-checking bench for data_mem_responder
//            (ADDR_W=10, WAIT_CYCLES=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 2;

  localparam logic [31:0] D_BEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] D_CAFE = 32'hCAFE_F00D;
  localparam logic [31:0] D_A    = 32'hA5A5_0001;
  localparam logic [31:0] D_B    = 32'h5A5A_0002;
  localparam logic [31:0] D_FIN  = 32'h55AA_1234;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              fin_sign;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [31:0]       dump_data;
  logic              dump_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .fin_sign   (fin_sign),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  // Present a request for one cycle; returns 1 time unit after its accept edge.
  task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; fin_sign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL rst_dump_valid: got %b want 0", dump_valid); end
    total++; if (dump_addr !== '0) begin bad++; $display("FAIL rst_dump_addr: got %h want 0", dump_addr); end
    total++; if (dump_data !== 32'h0) begin bad++; $display("FAIL rst_dump_data: got %h want 0", dump_data); end
    total++; if (dump_done !== 1'b0) begin bad++; $display("FAIL rst_dump_done: got %b want 0", dump_done); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_in_reset: got %b want 0", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", req_ready); end
  endtask

  // Store then load back; also seeds 0x20 for the reset-abort scenario.
  task automatic test_store_load();
    logic        w_t [3];
    logic [31:0] a_t [3];
    logic [31:0] d_t [3];
    logic [31:0] r_t [3];
    w_t[0] = 1'b1; a_t[0] = 32'h10; d_t[0] = D_BEEF; r_t[0] = 32'h0;
    w_t[1] = 1'b0; a_t[1] = 32'h10; d_t[1] = 32'h0;  r_t[1] = D_BEEF;
    w_t[2] = 1'b1; a_t[2] = 32'h20; d_t[2] = D_CAFE; r_t[2] = 32'h0;
    for (int n = 0; n < 3; n++) begin
      drive_req(w_t[n], a_t[n], d_t[n]);
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL sl%0d_ready_k0: got %b want 0", n, req_ready); end
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk);
        #1;
        total++; if (resp_valid !== (k == 2)) begin bad++; $display("FAIL sl%0d_resp_valid_k%0d: got %b want %b", n, k, resp_valid, (k == 2)); end
        total++; if (req_ready !== (k == 3)) begin bad++; $display("FAIL sl%0d_ready_k%0d: got %b want %b", n, k, req_ready, (k == 3)); end
        if (k == 2) begin
          total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL sl%0d_err: got %b want 0", n, resp_err); end
          total++; if (resp_rdata !== r_t[n]) begin bad++; $display("FAIL sl%0d_rdata: got %h want %h", n, resp_rdata, r_t[n]); end
        end
      end
    end
  endtask

  // Misaligned and out-of-range accesses; the erroneous stores alias word 4
  // if the checks were missing, so reload 0x10 afterwards.
  task automatic test_errors();
    logic        w_t [5];
    logic [31:0] a_t [5];
    logic [31:0] d_t [5];
    logic        e_t [5];
    logic [31:0] r_t [5];
    w_t[0] = 1'b1; a_t[0] = 32'h12;   d_t[0] = 32'h1111_1111; e_t[0] = 1'b1; r_t[0] = 32'h0;
    w_t[1] = 1'b1; a_t[1] = 32'h1010; d_t[1] = 32'h2222_2222; e_t[1] = 1'b1; r_t[1] = 32'h0;
    w_t[2] = 1'b0; a_t[2] = 32'h12;   d_t[2] = 32'h0;         e_t[2] = 1'b1; r_t[2] = 32'h0;
    w_t[3] = 1'b0; a_t[3] = 32'h1000; d_t[3] = 32'h0;         e_t[3] = 1'b1; r_t[3] = 32'h0;
    w_t[4] = 1'b0; a_t[4] = 32'h10;   d_t[4] = 32'h0;         e_t[4] = 1'b0; r_t[4] = D_BEEF;
    for (int n = 0; n < 5; n++) begin
      drive_req(w_t[n], a_t[n], d_t[n]);
      repeat (2) @(posedge clk);
      #1;
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL er%0d_resp_valid: got %b want 1", n, resp_valid); end
      total++; if (resp_err !== e_t[n]) begin bad++; $display("FAIL er%0d_err: got %b want %b", n, resp_err, e_t[n]); end
      total++; if (resp_rdata !== r_t[n]) begin bad++; $display("FAIL er%0d_rdata: got %h want %h", n, resp_rdata, r_t[n]); end
      @(posedge clk);
      #1;
    end
  endtask

  // Reset lands on the would-be commit edge of a store to 0x20.
  task automatic test_reset_abort();
    int fires;
    fires = 0;
    drive_req(1'b1, 32'h20, 32'h1234_5678);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    if (resp_valid) fires++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (resp_valid) fires++;
    end
    total++; if (fires !== 0) begin bad++; $display("FAIL abort_no_resp: got %0d pulses want 0", fires); end
    drive_req(1'b0, 32'h20, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL abort_load_valid: got %b want 1", resp_valid); end
    total++; if (resp_rdata !== D_CAFE) begin bad++; $display("FAIL abort_old_value: got %h want %h", resp_rdata, D_CAFE); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic        w_t [4];
    logic [31:0] a_t [4];
    logic [31:0] d_t [4];
    logic [31:0] r_t [4];
    int          acc_cyc [4];
    int          rsp_cyc [4];
    int          n_acc;
    int          n_rsp;
    logic        rdy;
    w_t[0] = 1'b1; a_t[0] = 32'h30; d_t[0] = D_A;   r_t[0] = 32'h0;
    w_t[1] = 1'b0; a_t[1] = 32'h30; d_t[1] = 32'h0; r_t[1] = D_A;
    w_t[2] = 1'b1; a_t[2] = 32'h34; d_t[2] = D_B;   r_t[2] = 32'h0;
    w_t[3] = 1'b0; a_t[3] = 32'h34; d_t[3] = 32'h0; r_t[3] = D_B;
    n_acc = 0;
    n_rsp = 0;
    for (int i = 0; i < 4; i++) begin acc_cyc[i] = -100; rsp_cyc[i] = -100; end
    @(negedge clk);
    req_valid = 1'b1; req_write = w_t[0]; req_addr = a_t[0]; req_wdata = d_t[0];
    for (int c = 0; c < 40; c++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy && req_valid && n_acc < 4) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      #1;
      if (resp_valid) begin
        if (n_rsp < 4) begin
          total++; if (resp_rdata !== r_t[n_rsp]) begin bad++; $display("FAIL b2b_rdata%0d: got %h want %h", n_rsp, resp_rdata, r_t[n_rsp]); end
          rsp_cyc[n_rsp] = c;
        end
        n_rsp++;
      end
      @(negedge clk);
      if (n_acc < 4) begin
        req_write = w_t[n_acc]; req_addr = a_t[n_acc]; req_wdata = d_t[n_acc];
      end else begin
        req_valid = 1'b0;
      end
    end
    total++; if (n_acc !== 4) begin bad++; $display("FAIL b2b_accepts: got %0d want 4", n_acc); end
    total++; if (n_rsp !== 4) begin bad++; $display("FAIL b2b_responses: got %0d want 4", n_rsp); end
    for (int i = 1; i < 4; i++) begin
      total++; if (acc_cyc[i] - acc_cyc[i-1] !== 4) begin bad++; $display("FAIL b2b_spacing%0d: got %0d want 4", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (rsp_cyc[i] - acc_cyc[i] !== 2) begin bad++; $display("FAIL b2b_latency%0d: got %0d want 2", i, rsp_cyc[i] - acc_cyc[i]); end
    end
  endtask

  // fin_sign pulsed one cycle after a store accept: store completes, then dump.
  task automatic test_fin_after_store();
    int          wait_n;
    int          addr_bad;
    int          other_bad;
    int          hold_bad;
    logic [31:0] cap4, cap8, cap12, cap13;
    wait_n = 0; addr_bad = 0; other_bad = 0; hold_bad = 0;
    cap4 = '0; cap8 = '0; cap12 = '0; cap13 = '0;
    drive_req(1'b1, 32'h10, D_FIN);
    @(negedge clk);
    fin_sign = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    fin_sign = 1'b0;
    @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL fin_store_valid: got %b want 1", resp_valid); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL fin_store_err: got %b want 0", resp_err); end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      wait_n = k;
      if (dump_valid) break;
    end
    total++; if (wait_n !== 2 || dump_valid !== 1'b1) begin bad++; $display("FAIL fin_dump_start: got %0d cycles valid=%b want 2 valid=1", wait_n, dump_valid); end
    for (int i = 0; i < 1024; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (dump_valid !== 1'b1 || dump_addr !== ADDR_W'(i)) addr_bad++;
      if (dump_done !== 1'b0 || resp_valid !== 1'b0) other_bad++;
      if (i == 4)  cap4  = dump_data;
      if (i == 8)  cap8  = dump_data;
      if (i == 12) cap12 = dump_data;
      if (i == 13) cap13 = dump_data;
    end
    total++; if (addr_bad !== 0) begin bad++; $display("FAIL fin_dump_sequence: got %0d bad words want 0", addr_bad); end
    total++; if (other_bad !== 0) begin bad++; $display("FAIL fin_dump_side: got %0d bad cycles want 0", other_bad); end
    total++; if (cap4 !== D_FIN) begin bad++; $display("FAIL fin_word4: got %h want %h", cap4, D_FIN); end
    total++; if (cap8 !== D_CAFE) begin bad++; $display("FAIL fin_word8: got %h want %h", cap8, D_CAFE); end
    total++; if (cap12 !== D_A) begin bad++; $display("FAIL fin_word12: got %h want %h", cap12, D_A); end
    total++; if (cap13 !== D_B) begin bad++; $display("FAIL fin_word13: got %h want %h", cap13, D_B); end
    @(posedge clk);
    #1;
    total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL fin_dump_end_valid: got %b want 0", dump_valid); end
    total++; if (dump_done !== 1'b1) begin bad++; $display("FAIL fin_done_rise: got %b want 1", dump_done); end
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (req_ready !== 1'b0 || dump_done !== 1'b1 || resp_valid !== 1'b0) hold_bad++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL fin_done_hold: got %0d bad cycles want 0", hold_bad); end
  endtask

  // fin_sign and req_valid together in IDLE: the dump wins, no response.
  task automatic test_fin_idle();
    int          wait_n;
    int          addr_bad;
    int          resp_fires;
    logic [31:0] cap4;
    wait_n = 0; addr_bad = 0; resp_fires = 0; cap4 = '0;
    apply_reset();
    #1;
    total++; if (dump_done !== 1'b0) begin bad++; $display("FAIL idle_rst_done: got %b want 0", dump_done); end
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; fin_sign = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    fin_sign = 1'b0;
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      wait_n = k;
      if (resp_valid) resp_fires++;
      if (dump_valid) break;
    end
    total++; if (wait_n !== 1 || dump_valid !== 1'b1) begin bad++; $display("FAIL idle_dump_start: got %0d cycles valid=%b want 1 valid=1", wait_n, dump_valid); end
    for (int i = 0; i < 1024; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (dump_valid !== 1'b1 || dump_addr !== ADDR_W'(i)) addr_bad++;
      if (resp_valid) resp_fires++;
      if (i == 4) cap4 = dump_data;
    end
    total++; if (resp_fires !== 0) begin bad++; $display("FAIL idle_no_resp: got %0d pulses want 0", resp_fires); end
    total++; if (addr_bad !== 0) begin bad++; $display("FAIL idle_dump_sequence: got %0d bad words want 0", addr_bad); end
    total++; if (cap4 !== D_FIN) begin bad++; $display("FAIL idle_word4_kept: got %h want %h", cap4, D_FIN); end
    @(posedge clk);
    #1;
    total++; if (dump_done !== 1'b1) begin bad++; $display("FAIL idle_done: got %b want 1", dump_done); end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_fin_after_store();
    test_fin_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
